// File: rtl/sudoku_checker.sv
// Scans a 9x9 board through a combinational read port, one cell per cycle, and
// checks that every row, column and 3x3 box holds 1..9 exactly once.
module sudoku_checker (
    input  logic       clka,
    input  logic       restart,
    input  logic       check_flag,
    output logic [6:0] rd_addr,
    input  logic [3:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       solved,
    output logic [4:0] fail_group
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;
    localparam logic [4:0] NO_FAIL   = 5'd31;
    localparam logic [4:0] LAST_G    = 5'd26;
    localparam logic [3:0] LAST_K    = 4'd8;

    logic [1:0] state_q, state_d;
    logic [4:0] g_q, g_d;
    logic [3:0] k_q, k_d;
    logic [8:0] seen_q, seen_d;
    logic       solved_q, solved_d;
    logic [4:0] fail_group_q, fail_group_d;

    // Upper two bits: v/3, lower two bits: v%3, for v in 0..8.
    function automatic logic [3:0] divmod3(input logic [3:0] v);
        case (v)
            4'd0:    divmod3 = 4'b00_00;
            4'd1:    divmod3 = 4'b00_01;
            4'd2:    divmod3 = 4'b00_10;
            4'd3:    divmod3 = 4'b01_00;
            4'd4:    divmod3 = 4'b01_01;
            4'd5:    divmod3 = 4'b01_10;
            4'd6:    divmod3 = 4'b10_00;
            4'd7:    divmod3 = 4'b10_01;
            4'd8:    divmod3 = 4'b10_10;
            default: divmod3 = 4'b00_00;
        endcase
    endfunction

    // One-hot decode of the cell value; 0 and 10..15 decode to all-zero.
    logic [8:0] val_onehot;
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_val_dec
            assign val_onehot[gi] = (rd_data == 4'(gi + 1));
        end
    endgenerate

    logic cell_bad;
    assign cell_bad = (val_onehot == 9'd0) || ((val_onehot & seen_q) != 9'd0);

    logic [4:0] g_off;
    logic [3:0] box_dm, k_dm, row_idx, col_idx;
    logic [6:0] cell_addr;

    always_comb begin
        g_off   = 5'd0;
        box_dm  = 4'd0;
        k_dm    = divmod3(k_q);
        row_idx = 4'd0;
        col_idx = 4'd0;
        if (g_q < 5'd9) begin
            row_idx = g_q[3:0];
            col_idx = k_q;
        end else if (g_q < 5'd18) begin
            g_off   = g_q - 5'd9;
            row_idx = k_q;
            col_idx = g_off[3:0];
        end else begin
            g_off   = g_q - 5'd18;
            box_dm  = divmod3(g_off[3:0]);
            row_idx = {2'b00, box_dm[3:2]} * 4'd3 + {2'b00, k_dm[3:2]};
            col_idx = {2'b00, box_dm[1:0]} * 4'd3 + {2'b00, k_dm[1:0]};
        end
        cell_addr = {3'b000, row_idx} * 7'd9 + {3'b000, col_idx};
    end

    always_comb begin
        state_d      = state_q;
        g_d          = g_q;
        k_d          = k_q;
        seen_d       = seen_q;
        solved_d     = solved_q;
        fail_group_d = fail_group_q;
        case (state_q)
            ST_IDLE: begin
                if (check_flag) begin
                    state_d      = ST_SCAN;
                    solved_d     = 1'b0;
                    fail_group_d = NO_FAIL;
                    g_d          = 5'd0;
                    k_d          = 4'd0;
                    seen_d       = 9'd0;
                end
            end
            ST_SCAN: begin
                if (cell_bad) begin
                    fail_group_d = g_q;
                    solved_d     = 1'b0;
                    state_d      = ST_FINISH;
                end else if (k_q == LAST_K) begin
                    seen_d = 9'd0;
                    k_d    = 4'd0;
                    if (g_q == LAST_G) begin
                        solved_d = 1'b1;
                        state_d  = ST_FINISH;
                    end else begin
                        g_d = g_q + 5'd1;
                    end
                end else begin
                    seen_d = seen_q | val_onehot;
                    k_d    = k_q + 4'd1;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (restart) begin
            state_q      <= ST_IDLE;
            g_q          <= 5'd0;
            k_q          <= 4'd0;
            seen_q       <= 9'd0;
            solved_q     <= 1'b0;
            fail_group_q <= NO_FAIL;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            k_q          <= k_d;
            seen_q       <= seen_d;
            solved_q     <= solved_d;
            fail_group_q <= fail_group_d;
        end
    end

    assign rd_addr    = (state_q == ST_SCAN) ? cell_addr : 7'd0;
    assign busy       = (state_q == ST_SCAN);
    assign done       = (state_q == ST_FINISH);
    assign solved     = solved_q;
    assign fail_group = fail_group_q;

endmodule
